// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the decode-to-execute issue scoreboard.
// Tracks RV32E destination registers and the issue/drain control state.
package issue_pkg;

    typedef enum logic {ISS_RUN, ISS_DRAIN} issue_state;

    localparam int RV32E_NUM_REGS = 16;
    localparam int REG_IDX_W      = 5;

    // Width of a counter that must hold the values 0..max_pending inclusive.
    function automatic int pending_cnt_w(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-execute handshake with the decoded register usage of the instruction.
// The master is the pipeline side (decode drives, execute accepts); the slave is the scoreboard.
interface issue_scoreboard_if;
    import issue_pkg::*;

    logic                 dec_valid;
    logic                 dec_ready;
    logic [REG_IDX_W-1:0] dec_rs1;
    logic [REG_IDX_W-1:0] dec_rs2;
    logic [REG_IDX_W-1:0] dec_rd;
    logic                 dec_uses_rs1;
    logic                 dec_uses_rs2;
    logic                 dec_writes_rd;
    logic                 iss_valid;
    logic                 iss_ready;
    logic                 iss_illegal;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
               dec_uses_rs1, dec_uses_rs2, dec_writes_rd, iss_ready,
        input  dec_ready, iss_valid, iss_illegal
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
               dec_uses_rs1, dec_uses_rs2, dec_writes_rd, iss_ready,
        output dec_ready, iss_valid, iss_illegal
    );

endinterface

// File: rtl/issue_scoreboard_reg_pending_counter.sv
// Outstanding-write counter for one register: saturates at 0 and MAX_PENDING.
// A decrement is only honoured when something is pending, so inc+dec at zero still counts up.
module reg_pending_counter #(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_zero,
    output logic             is_full
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             dec_eff;

    assign is_zero = (count_reg == '0);
    assign is_full = (count_reg == CNT_W'(MAX_PENDING));
    assign dec_eff = dec && !is_zero;
    assign count   = count_reg;

    always_comb begin
        count_next = count_reg;
        if (inc && !dec_eff && !is_full) begin
            count_next = count_reg + 1'b1;
        end else if (dec_eff && !inc) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: stalls decode->execute on RAW/WAW hazards against pending register
// writes and drains all outstanding writes after a flush before issuing again.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int NUM_REGS    = RV32E_NUM_REGS,
    parameter int MAX_PENDING = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    issue_scoreboard_if.slave    bus,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 flush,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic                 wb_error
);

    localparam int CNT_W = pending_cnt_w(MAX_PENDING);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [REG_IDX_W-1:0] NUM_REGS_IDX = REG_IDX_W'(NUM_REGS);

    issue_state           state_reg;
    issue_state           state_next;
    logic                 wb_error_reg;
    logic                 wb_error_next;
    logic [NUM_REGS-1:0]  pend_vec;
    logic [NUM_REGS-1:0]  full_vec;
    logic [CNT_W-1:0]     counts [1:NUM_REGS-1];
    logic                 all_zero;
    logic                 hazard;
    logic                 illegal;
    logic                 fire;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 rd_full;

    function automatic logic in_range(input logic [REG_IDX_W-1:0] idx);
        return idx < NUM_REGS_IDX;
    endfunction

    // x0 is never tracked: its slots are tied off so index 0 can never hazard.
    assign pend_vec[0] = 1'b0;
    assign full_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic inc;
            logic dec;
            logic zero;

            assign inc = fire && bus.dec_writes_rd && (bus.dec_rd == REG_IDX_W'(gi));
            assign dec = wb_valid && (wb_rd == REG_IDX_W'(gi));

            reg_pending_counter #(
                .MAX_PENDING (MAX_PENDING),
                .CNT_W       (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (inc),
                .dec     (dec),
                .count   (counts[gi]),
                .is_zero (zero),
                .is_full (full_vec[gi])
            );

            assign pend_vec[gi] = !zero;
        end
    endgenerate

    always_comb begin
        all_zero = 1'b1;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (counts[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    // Hazards look only at registered counters; a same-cycle writeback does not release a stall.
    assign rs1_busy = bus.dec_uses_rs1 && in_range(bus.dec_rs1) && pend_vec[bus.dec_rs1[IDX_W-1:0]];
    assign rs2_busy = bus.dec_uses_rs2 && in_range(bus.dec_rs2) && pend_vec[bus.dec_rs2[IDX_W-1:0]];
    assign rd_full  = bus.dec_writes_rd && in_range(bus.dec_rd) && full_vec[bus.dec_rd[IDX_W-1:0]];
    assign hazard   = rs1_busy || rs2_busy || rd_full;

    assign illegal = (bus.dec_uses_rs1  && !in_range(bus.dec_rs1)) ||
                     (bus.dec_uses_rs2  && !in_range(bus.dec_rs2)) ||
                     (bus.dec_writes_rd && !in_range(bus.dec_rd));

    assign bus.iss_valid   = reset_n && bus.dec_valid && !hazard && (state_reg == ISS_RUN) && !flush;
    assign bus.dec_ready   = bus.iss_valid && bus.iss_ready;
    assign bus.iss_illegal = bus.iss_valid && illegal;
    assign fire            = bus.dec_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ISS_RUN:   if (flush) state_next = ISS_DRAIN;
            ISS_DRAIN: if (all_zero && !flush) state_next = ISS_RUN;
            default:   state_next = ISS_RUN;
        endcase
    end

    assign wb_error_next = wb_valid && in_range(wb_rd) && (wb_rd != '0) &&
                           !pend_vec[wb_rd[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ISS_RUN;
            wb_error_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_error_reg <= wb_error_next;
        end
    end

    assign busy_mask = pend_vec;
    assign wb_error  = wb_error_reg;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed and random checks of issue_scoreboard against a per-register pending-count model.
module tb_issue_scoreboard;
    import issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [15:0] busy_mask;
    logic        wb_error;

    always #5 clk = ~clk;

    issue_scoreboard_if bus_if();

    issue_scoreboard #(.NUM_REGS(16), .MAX_PENDING(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .busy_mask (busy_mask),
        .wb_error  (wb_error)
    );

    int   m_cnt [16];
    bit   m_drain;
    bit   m_err;
    bit   m_known;
    int   checks;
    int   errors;
    logic        last_iv, last_rdy, last_ill, last_err;
    logic [15:0] last_bm;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending(input int i);
        return (i > 0 && i < 16) ? (m_cnt[i] > 0) : 1'b0;
    endfunction

    task automatic set_dec(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                           input int rd, input bit w);
        bus_if.dec_valid     = v;
        bus_if.dec_rs1       = 5'(rs1);
        bus_if.dec_uses_rs1  = u1;
        bus_if.dec_rs2       = 5'(rs2);
        bus_if.dec_uses_rs2  = u2;
        bus_if.dec_rd        = 5'(rd);
        bus_if.dec_writes_rd = w;
    endtask

    task automatic set_wb(input bit v, input int rd);
        wb_valid = v;
        wb_rd    = 5'(rd);
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic tick(input string tag);
        int rs1, rs2, rd, wb, inc_r, dec_r;
        bit hz, iv, rdy, ill, all_zero, fire;
        logic [15:0] bm;
        #1;
        rs1 = int'(bus_if.dec_rs1);
        rs2 = int'(bus_if.dec_rs2);
        rd  = int'(bus_if.dec_rd);
        wb  = int'(wb_rd);
        hz  = (bus_if.dec_uses_rs1 && pending(rs1)) || (bus_if.dec_uses_rs2 && pending(rs2)) ||
              (bus_if.dec_writes_rd && rd > 0 && rd < 16 && m_cnt[rd] == 3);
        iv  = reset_n && bus_if.dec_valid && !hz && !m_drain && !flush;
        rdy = iv && bus_if.iss_ready;
        ill = iv && ((bus_if.dec_uses_rs1 && rs1 >= 16) || (bus_if.dec_uses_rs2 && rs2 >= 16) ||
                     (bus_if.dec_writes_rd && rd >= 16));
        chk({tag, ".iss_valid"}, 16'(bus_if.iss_valid), 16'(iv));
        chk({tag, ".dec_ready"}, 16'(bus_if.dec_ready), 16'(rdy));
        chk({tag, ".iss_illegal"}, 16'(bus_if.iss_illegal), 16'(ill));
        if (m_known) begin
            bm = '0;
            for (int i = 1; i < 16; i++) bm[i] = (m_cnt[i] != 0);
            chk({tag, ".busy_mask"}, busy_mask, bm);
            chk({tag, ".wb_error"}, 16'(wb_error), 16'(m_err));
        end
        last_iv  = bus_if.iss_valid;
        last_rdy = bus_if.dec_ready;
        last_ill = bus_if.iss_illegal;
        last_err = wb_error;
        last_bm  = busy_mask;
        fire     = rdy;
        @(posedge clk);
        if (!reset_n) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_drain = 0;
            m_err   = 0;
            m_known = 1;
        end else begin
            all_zero = 1;
            for (int i = 1; i < 16; i++) if (m_cnt[i] != 0) all_zero = 0;
            m_err = wb_valid && wb > 0 && wb < 16 && m_cnt[wb] == 0;
            inc_r = (fire && bus_if.dec_writes_rd && rd > 0 && rd < 16) ? rd : -1;
            dec_r = (wb_valid && wb > 0 && wb < 16 && m_cnt[wb] > 0) ? wb : -1;
            if (inc_r != dec_r) begin
                if (inc_r > 0) m_cnt[inc_r]++;
                if (dec_r > 0) m_cnt[dec_r]--;
            end
            if (!m_drain && flush) m_drain = 1;
            else if (m_drain && all_zero && !flush) m_drain = 0;
        end
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_known = 0;
        m_drain = 0;
        m_err   = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;

        // Reset while decode offers an instruction.
        reset_n = 0;
        flush   = 0;
        bus_if.iss_ready = 1;
        set_dec(1, 1, 1, 2, 1, 3, 1);
        set_wb(0, 0);
        tick("rst0");
        tick("rst1");
        chk("rst.iss_valid", 16'(last_iv), 16'h0);
        chk("rst.dec_ready", 16'(last_rdy), 16'h0);
        reset_n = 1;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        tick("idle");
        chk("rst.busy_mask", last_bm, 16'h0);

        // RAW on x5, released exactly one cycle after the writeback cycle.
        set_dec(1, 0, 0, 0, 0, 5, 1);
        tick("t2.wr");
        chk("t2.wr_fire", 16'(last_rdy), 16'h1);
        set_dec(1, 5, 1, 0, 0, 6, 0);
        tick("t2.stall");
        chk("t2.stall", 16'(last_iv), 16'h0);
        set_wb(1, 5);
        tick("t2.wb");
        chk("t2.wb_cycle", 16'(last_iv), 16'h0);
        set_wb(0, 0);
        tick("t2.go");
        chk("t2.go", 16'(last_iv), 16'h1);
        set_dec(0, 0, 0, 0, 0, 0, 0);

        // x7 saturates at three outstanding writes.
        set_dec(1, 0, 0, 0, 0, 7, 1);
        repeat (3) tick("t3.wr");
        tick("t3.stall4");
        chk("t3.stall4", 16'(last_iv), 16'h0);
        chk("t3.busy7", 16'(last_bm[7]), 16'h1);
        set_wb(1, 7);
        tick("t3.wb");
        chk("t3.wb_cycle", 16'(last_iv), 16'h0);
        set_wb(0, 0);
        tick("t3.go");
        chk("t3.go", 16'(last_iv), 16'h1);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 7);
        repeat (3) tick("t3.clr");
        set_wb(0, 0);

        // Simultaneous issue and writeback to x3 leaves the count at one.
        set_dec(1, 0, 0, 0, 0, 3, 1);
        tick("t4.wr");
        set_wb(1, 3);
        tick("t4.both");
        chk("t4.both_fire", 16'(last_rdy), 16'h1);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
        tick("t4.after");
        chk("t4.busy3", 16'(last_bm[3]), 16'h1);
        set_wb(1, 3);
        tick("t4.clr");
        set_wb(0, 0);

        // Flush drains x2 before issue resumes.
        set_dec(1, 0, 0, 0, 0, 2, 1);
        tick("t5.wr");
        flush = 1;
        set_dec(1, 0, 0, 0, 0, 4, 1);
        tick("t5.flush");
        chk("t5.flush_blocked", 16'(last_iv), 16'h0);
        flush = 0;
        repeat (2) tick("t5.drain");
        set_wb(1, 2);
        tick("t5.wb");
        set_wb(0, 0);
        tick("t5.zero");
        chk("t5.still_drain", 16'(last_iv), 16'h0);
        tick("t5.run");
        chk("t5.resume", 16'(last_iv), 16'h1);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 4);
        tick("t5.clr");
        set_wb(0, 0);

        // Edge cases: stray writeback, illegal index, x0 and out-of-range destinations.
        set_wb(1, 9);
        tick("t6.wb9");
        set_wb(0, 0);
        tick("t6.err");
        chk("t6.wb_error", 16'(last_err), 16'h1);
        chk("t6.bm_clean", last_bm, 16'h0);
        tick("t6.err_clear");
        chk("t6.wb_error_pulse", 16'(last_err), 16'h0);
        set_dec(1, 1, 0, 20, 1, 0, 0);
        tick("t6.ill");
        chk("t6.ill_valid", 16'(last_iv), 16'h1);
        chk("t6.ill_flag", 16'(last_ill), 16'h1);
        set_dec(1, 0, 0, 0, 0, 0, 1);
        tick("t6.rd0");
        set_dec(1, 0, 0, 0, 0, 18, 1);
        tick("t6.rd18");
        set_dec(0, 0, 0, 0, 0, 0, 0);
        tick("t6.after");
        chk("t6.rd0_untracked", last_bm, 16'h0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            set_dec($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 7),
                    $urandom_range(0, 1),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 7),
                    $urandom_range(0, 1),
                    ($urandom_range(0, 15) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 7),
                    $urandom_range(0, 3) != 0);
            bus_if.iss_ready = $urandom_range(0, 3) != 0;
            set_wb($urandom_range(0, 1),
                   ($urandom_range(0, 15) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7));
            flush = ($urandom_range(0, 39) == 0);
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
